// File: rtl/ladybird_fetch_pkg.sv
// Shared configuration for the ladybird core: machine width, fetch entry
// layout and the fetch flush state encoding.
package ladybird_config;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // FETCH_DRAIN means stale responses from before a redirect are still in flight.
  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ladybird_bus.sv
// Instruction/data RAM bus. The primary side issues requests; the secondary
// side grants them and returns read data in order, without backpressure.
interface ladybird_bus;
  import ladybird_config::*;

  logic                  req;
  logic                  gnt;
  logic [XLEN-1:0]       addr;
  logic [INST_BYTES-1:0] wstrb;
  logic [XLEN-1:0]       data;
  logic                  data_gnt;

  modport primary (
    output req, addr, wstrb,
    input  gnt, data, data_gnt
  );

  modport secondary (
    input  req, addr, wstrb,
    output gnt, data, data_gnt
  );

endinterface

// File: rtl/ladybird_sync_fifo.sv
// Synchronous FIFO with registered storage, clear and simultaneous push/pop
// (also when full). DEPTH must be a power of two, at least 2.
module ladybird_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ladybird_fetch.sv
// Instruction fetch: credit-limited sequential reads on the RAM bus, in-order
// response buffering, and redirect handling that discards in-flight words.
module ladybird_fetch
  import ladybird_config::*;
#(
  parameter logic [XLEN-1:0] INIT_PC         = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst,
  ladybird_bus.primary     bus,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Decode handshake: an entry transfers in any cycle where inst_valid and
  // inst_ready are both high; inst_valid never depends on inst_ready, and the
  // head stays stable until it transfers (a redirect drops it instead).

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_nxt;
  logic [OW-1:0]   discard_cnt;
  logic [OW-1:0]   discard_nxt;
  fetch_state_t    state;
  fetch_state_t    state_nxt;

  logic            accept;
  logic            drop;
  logic            push;
  logic            pop;
  logic            credit_ok;
  logic            slot_ok;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Every accepted request must have a FIFO slot waiting, since the RAM cannot stall.
  assign credit_ok = int'(outstanding) < MAX_OUTSTANDING;
  assign slot_ok   = (int'(outstanding) + int'(count)) < FIFO_DEPTH;

  assign bus.req   = ~rst & ~redirect & credit_ok & slot_ok;
  assign bus.addr  = {pc[XLEN-1:2], 2'b00};
  assign bus.wstrb = '0;

  assign accept = bus.req & bus.gnt;
  assign drop   = bus.data_gnt & (redirect | (state == FETCH_DRAIN));
  assign push   = bus.data_gnt & ~drop;
  assign pop    = inst_valid & inst_ready & ~redirect;

  assign wr_entry.pc   = resp_pc;
  assign wr_entry.inst = bus.data;

  assign outstanding_nxt = outstanding + OW'(accept) - OW'(bus.data_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= INIT_PC;
      resp_pc <= INIT_PC;
    end else if (redirect) begin
      pc      <= redirect_aligned;
      resp_pc <= redirect_aligned;
    end else begin
      if (accept) pc      <= pc + XLEN'(INST_BYTES);
      if (push)   resp_pc <= resp_pc + XLEN'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard_cnt <= '0;
      state       <= FETCH_RUN;
    end else begin
      outstanding <= outstanding_nxt;
      discard_cnt <= discard_nxt;
      state       <= state_nxt;
    end
  end

  always_comb begin
    discard_nxt = discard_cnt;
    state_nxt   = state;
    // At a redirect every response still in flight belongs to the old stream.
    if (redirect) begin
      discard_nxt = outstanding - OW'(bus.data_gnt);
    end else if (bus.data_gnt && (state == FETCH_DRAIN)) begin
      discard_nxt = discard_cnt - 1'b1;
    end
    case (state)
      FETCH_RUN:   if (discard_nxt != '0) state_nxt = FETCH_DRAIN;
      FETCH_DRAIN: if (discard_nxt == '0) state_nxt = FETCH_RUN;
      default:     state_nxt = FETCH_RUN;
    endcase
  end

  ladybird_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign inst_valid = ~empty;
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !redirect))
    else $error("fetch buffer overflow");

endmodule

// File: tb/tb_ladybird_fetch.sv
// Bench for ladybird_fetch: a latency-configurable RAM on the bus and a
// stream-level model of what decode must see, checked every cycle.
module tb_ladybird_fetch;
  import ladybird_config::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  ladybird_bus bus_if ();

  ladybird_fetch #(
    .INIT_PC         (32'h0000_0000),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus state and model ----------------
  typedef struct {
    int          due;
    logic [5:0]  idx;
    logic [31:0] pc;
    int          epoch;
  } rsp_t;

  logic [31:0] mem [64];
  rsp_t        rq[$];
  rsp_t        cur_rsp;
  logic [63:0] exp_q[$];

  logic        rst_v, redirect_v, gnt_v, ready_v;
  logic [31:0] rpc_v;
  int          lat;
  int          cyc;
  int          epoch;
  int          out_m;
  logic [31:0] issue_pc;
  logic        hold_q;
  logic [31:0] hold_addr;
  logic        prev_rst;
  int          n_pop;

  logic        s_req, s_valid, s_dg;
  logic [31:0] s_addr, s_inst, s_pc;
  int          s_out;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver + compare (one call per clock cycle) ----------------
  task automatic step();
    @(negedge clk);
    rst         = rst_v;
    redirect    = redirect_v;
    redirect_pc = rpc_v;
    inst_ready  = ready_v;
    bus_if.gnt  = gnt_v;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      cur_rsp         = rq.pop_front();
      bus_if.data_gnt = 1'b1;
      bus_if.data     = mem[cur_rsp.idx];
    end else begin
      bus_if.data_gnt = 1'b0;
      bus_if.data     = $urandom;
    end
    #1;
    s_req   = bus_if.req;
    s_addr  = bus_if.addr;
    s_valid = inst_valid;
    s_inst  = inst;
    s_pc    = inst_pc;
    s_dg    = bus_if.data_gnt;
    s_out   = out_m;

    check("wstrb_zero", 64'(bus_if.wstrb), 64'(0));
    check("addr_aligned", 64'(s_addr[1:0]), 64'(0));
    check("inst_valid", 64'(s_valid), 64'(exp_q.size() != 0));

    if (rst_v) begin
      check("rst_req", 64'(s_req), 64'(0));
      if (prev_rst) begin
        check("rst_inst", 64'(s_inst), 64'(0));
        check("rst_inst_pc", 64'(s_pc), 64'(0));
        check("rst_addr", 64'(s_addr), 64'(0));
      end
      exp_q.delete();
      rq.delete();
      out_m    = 0;
      issue_pc = 32'h0;
      hold_q   = 1'b0;
    end else begin
      if (redirect_v) check("redirect_req_low", 64'(s_req), 64'(0));
      if (hold_q && !redirect_v) begin
        check("held_req", 64'(s_req), 64'(1));
        check("held_addr", 64'(s_addr), 64'(hold_addr));
      end
      if (s_valid && ready_v && !redirect_v && exp_q.size() != 0) begin
        check("pop_pc", 64'(s_pc), 64'(exp_q[0][63:32]));
        check("pop_inst", 64'(s_inst), 64'(exp_q[0][31:0]));
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (redirect_v) begin
        exp_q.delete();
        epoch++;
        issue_pc = {rpc_v[31:2], 2'b00};
      end
      if (s_dg) begin
        out_m--;
        if (cur_rsp.epoch == epoch) exp_q.push_back({cur_rsp.pc, mem[cur_rsp.idx]});
      end
      if (s_req && gnt_v) begin
        check("issue_addr", 64'(s_addr), 64'(issue_pc));
        rq.push_back('{due: cyc + lat, idx: issue_pc[7:2], pc: issue_pc, epoch: epoch});
        issue_pc = issue_pc + 32'd4;
        out_m++;
      end
      check("outstanding_bound", 64'(out_m <= MAX_OUT), 64'(1));
      check("buffer_bound", 64'(exp_q.size() <= DEPTH), 64'(1));
      hold_q    = s_req & ~gnt_v;
      hold_addr = s_addr;
    end
    prev_rst = rst_v;
    cyc      = rst_v ? 0 : cyc + 1;
  endtask

  task automatic do_reset(input int latency);
    lat        = latency;
    rst_v      = 1'b1;
    redirect_v = 1'b0;
    rpc_v      = 32'h0;
    gnt_v      = 1'b1;
    ready_v    = 1'b1;
    repeat (3) step();
    rst_v = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while (!s_valid && n < limit);
    if (!s_valid) check("wait_valid_timeout", 64'(0), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dg_cnt;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    cyc = 0; epoch = 0; out_m = 0; issue_pc = 0; hold_q = 0; hold_addr = 0;
    prev_rst = 1'b0; n_pop = 0; lat = 1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    bus_if.gnt = 1'b0; bus_if.data_gnt = 1'b0; bus_if.data = '0;

    // 1-cycle RAM, streaming
    do_reset(1);
    step();
    check("t1_req_c0", 64'(s_req), 64'(1));
    check("t1_addr_c0", 64'(s_addr), 64'(0));
    step();
    check("t1_dg_c1", 64'(s_dg), 64'(1));
    check("t1_valid_c1", 64'(s_valid), 64'(0));
    step();
    check("t1_valid_c2", 64'(s_valid), 64'(1));
    check("t1_pc_c2", 64'(s_pc), 64'(32'h0));
    check("t1_inst_c2", 64'(s_inst), 64'(32'h1000_0000));
    step();
    check("t1_pc_c3", 64'(s_pc), 64'(32'h4));
    check("t1_inst_c3", 64'(s_inst), 64'(32'h1000_0001));
    repeat (10) begin
      step();
      check("t1_sustained", 64'(s_valid), 64'(1));
    end

    // decode stalled for 10 cycles
    do_reset(1);
    ready_v = 1'b0;
    dg_cnt  = 0;
    repeat (10) begin
      step();
      if (s_dg) dg_cnt++;
    end
    check("t2_buffered", 64'(dg_cnt), 64'(4));
    check("t2_req_low", 64'(s_req), 64'(0));
    check("t2_valid", 64'(s_valid), 64'(1));
    check("t2_head_pc", 64'(s_pc), 64'(32'h0));
    ready_v = 1'b1;
    repeat (12) step();

    // 2-cycle RAM
    do_reset(2);
    repeat (3) begin
      step();
      check("t3_valid_early", 64'(s_valid), 64'(0));
    end
    step();
    check("t3_valid_c3", 64'(s_valid), 64'(1));
    check("t3_pc_c3", 64'(s_pc), 64'(32'h0));
    repeat (12) step();

    // redirect with two outstanding and a response in the same cycle
    do_reset(2);
    repeat (2) step();
    redirect_v = 1'b1;
    rpc_v      = 32'h24;
    step();
    check("t4_outstanding", 64'(s_out), 64'(2));
    check("t4_dg_same_cycle", 64'(s_dg), 64'(1));
    redirect_v = 1'b0;
    step();
    check("t4_empty_after", 64'(s_valid), 64'(0));
    wait_valid(10);
    check("t4_pc", 64'(s_pc), 64'(32'h24));
    check("t4_inst", 64'(s_inst), 64'(32'h1000_0009));
    repeat (4) step();

    // unaligned redirect target
    do_reset(1);
    repeat (4) step();
    redirect_v = 1'b1;
    rpc_v      = 32'h31;
    step();
    redirect_v = 1'b0;
    wait_valid(10);
    check("t5_pc", 64'(s_pc), 64'(32'h30));
    check("t5_inst", 64'(s_inst), 64'(32'h1000_000C));
    repeat (4) step();

    // grant withheld at pc 0x8
    do_reset(1);
    repeat (2) step();
    gnt_v = 1'b0;
    repeat (3) begin
      step();
      check("t6_addr_held", 64'(s_addr), 64'(32'h8));
      check("t6_req_held", 64'(s_req), 64'(1));
    end
    gnt_v = 1'b1;
    step();
    check("t6_addr_accept", 64'(s_addr), 64'(32'h8));
    step();
    check("t6_addr_next", 64'(s_addr), 64'(32'hC));
    repeat (8) step();

    // randomized segments
    for (int seg = 0; seg < 6; seg++) begin
      do_reset($urandom_range(1, 2));
      repeat (400) begin
        gnt_v      = ($urandom_range(0, 3) != 0);
        ready_v    = ($urandom_range(0, 3) != 0);
        redirect_v = ($urandom_range(0, 24) == 0);
        rpc_v      = $urandom_range(0, 255);
        step();
      end
      gnt_v = 1'b1; ready_v = 1'b1; redirect_v = 1'b0;
      n_pop = 0;
      repeat (20) step();
      check("liveness", 64'(n_pop >= 10), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
